// File: rtl/matriz_pkg.sv
// Shared definitions for the matrix loader and its position counter.
// Holds the matrix geometry constants, the slice-offset helper that matches
// the transposer's flattening convention, and the loader FSM state type.
// Optional feature macro used by this slice: CARREGADOR_ORDEM_COLUNA_EN.
package matriz_pkg;
  localparam int DIM         = 5;
  localparam int LARGURA     = 8;
  localparam int ELEMENTOS   = DIM * DIM;
  localparam int BITS_MATRIZ = ELEMENTOS * LARGURA;

  typedef enum logic {CARREGANDO, CHEIA} estado_t;

  // Bit offset of element (linha, coluna); the column index is the slow axis.
  function automatic int indice(input int linha, input int coluna);
    return LARGURA * (linha + DIM * coluna);
  endfunction
endpackage

// File: rtl/contador_posicao.sv
// Two-level mod-5 position counter for the matrix loader.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   incrementar  - advance one position
//   limpar       - synchronous return to (0,0), wins over incrementar
//   linha/coluna - current write position
//   ultimo       - position is (4,4)
// Macro CARREGADOR_ORDEM_COLUNA_EN: linha becomes the fast axis
// (column-major stream order); otherwise coluna is the fast axis.
module contador_posicao
  import matriz_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       incrementar,
  input  logic       limpar,
  output logic [2:0] linha,
  output logic [2:0] coluna,
  output logic       ultimo
);
  localparam logic [2:0] MAXIMO = 3'(DIM - 1);

  logic [2:0] rapido, lento;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rapido <= '0;
      lento  <= '0;
    end else if (limpar) begin
      rapido <= '0;
      lento  <= '0;
    end else if (incrementar) begin
      if (rapido == MAXIMO) begin
        rapido <= '0;
        lento  <= (lento == MAXIMO) ? 3'd0 : lento + 3'd1;
      end else begin
        rapido <= rapido + 3'd1;
      end
    end
  end

`ifdef CARREGADOR_ORDEM_COLUNA_EN
  assign linha  = rapido;
  assign coluna = lento;
`else
  assign linha  = lento;
  assign coluna = rapido;
`endif

  assign ultimo = (rapido == MAXIMO) && (lento == MAXIMO);
endmodule

// File: rtl/carregador_matriz.sv
// Serial-to-parallel loader feeding the 5x5 matrix transposer.
// Collects 25 signed elements over a valid/ready stream into a flattened
// 200-bit matrix and holds it with a valid/accept handshake.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   limpar         - synchronous abort: zero buffer, counters, back to loading
//   dado_entrada   - signed element, qualified by dado_valido
//   dado_pronto    - loader takes an element this cycle (state decode)
//   matriz_saida   - flattened matrix, element (l,c) at 8*(l+5*c)
//   matriz_valida  - matriz_saida holds a complete matrix (state decode)
//   matriz_aceita  - downstream takes the matrix
// Macro CARREGADOR_ORDEM_COLUNA_EN selects column-major stream order.
module carregador_matriz #(
  parameter int DIM     = 5,
  parameter int LARGURA = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       limpar,
  input  logic [LARGURA-1:0]         dado_entrada,
  input  logic                       dado_valido,
  output logic                       dado_pronto,
  output logic [DIM*DIM*LARGURA-1:0] matriz_saida,
  output logic                       matriz_valida,
  input  logic                       matriz_aceita
);
  import matriz_pkg::*;

  estado_t    estado;
  logic [2:0] linha, coluna;
  logic       ultimo;
  logic       transf;

  // Abort suppresses the write so a same-cycle element never lands.
  assign transf = dado_valido && (estado == CARREGANDO) && !limpar;

  contador_posicao u_contador (
    .clk         (clk),
    .rst_n       (rst_n),
    .incrementar (transf),
    .limpar      (limpar),
    .linha       (linha),
    .coluna      (coluna),
    .ultimo      (ultimo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= CARREGANDO;
    end else if (limpar) begin
      estado <= CARREGANDO;
    end else begin
      case (estado)
        CARREGANDO: if (transf && ultimo) estado <= CHEIA;
        CHEIA:      if (matriz_aceita)    estado <= CARREGANDO;
        default:                          estado <= CARREGANDO;
      endcase
    end
  end

  // Buffer is only cleared by reset/abort; a new load overwrites in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      matriz_saida <= '0;
    end else if (limpar) begin
      matriz_saida <= '0;
    end else if (transf) begin
      for (int l = 0; l < DIM; l++) begin
        for (int c = 0; c < DIM; c++) begin
          if (linha == 3'(l) && coluna == 3'(c))
            matriz_saida[indice(l, c) +: LARGURA] <= dado_entrada;
        end
      end
    end
  end

  assign dado_pronto   = (estado == CARREGANDO);
  assign matriz_valida = (estado == CHEIA);
endmodule
